axi_lite_wr_slave: RTL and testbench

AXI4-Lite write-channel responder: the slave end of the AW/W/B bus that the team's write-only AXI-Lite interface drives.
- Accepts address and data independently in either order, in one-entry holding buffers.
- Commits the byte-strobed write into a bank of 32-bit control registers and returns a write response on B.
- Sits behind the PS/testbench AXI-Lite master; the register bank drives the accelerator control inputs.

---
 rtl/axi_lite_pkg.sv | 12 +
 rtl/axi_lite_hold_buf.sv | 43 ++++
 rtl/axi_lite_wr_slave.sv | 98 +++++++++
 tb/tb_axi_lite_wr_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite widths and response codes
package axi_lite_pkg;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ADDR_WIDTH = 6;
    localparam int STRB_WIDTH     = AXI_DATA_WIDTH / 8;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;
endpackage

// File: rtl/axi_lite_hold_buf.sv
// axi_lite_hold_buf: one-entry valid/ready holding register with registered ready
module axi_lite_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         clr,
    output logic         full,
    output logic [W-1:0] data
);
    logic         full_q, full_d;
    logic         ready_q, ready_d;
    logic [W-1:0] data_q, data_d;
    logic         hs;

    // capture on handshake, empty on clear; ready mirrors the next empty state
    always_comb begin
        hs      = in_valid & ready_q;
        full_d  = clr ? 1'b0 : (hs ? 1'b1 : full_q);
        ready_d = ~full_d;
        data_d  = hs ? in_data : data_q;
    end

    // state registers; ready stays low during reset and rises on the first edge after
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign in_ready = ready_q;
    assign full     = full_q;
    assign data     = data_q;
endmodule

// File: rtl/axi_lite_wr_slave.sv
// axi_lite_wr_slave: AXI4-Lite write responder committing strobed writes into a register bank
module axi_lite_wr_slave
    import axi_lite_pkg::*;
#(
    parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int                    NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                           clk,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int NI = 2 ** IW;
    localparam int SW = DATA_WIDTH / 8;

    function automatic logic [NI-1:0] err_map();
        for (int i = 0; i < NI; i++)
            err_map[i] = (i >= NUM_REGS) ? 1'b1 : RO_MASK[i % NUM_REGS];
    endfunction

    localparam logic [NI-1:0] ERR_MAP = err_map();

    logic                               aw_full, w_full, commit, err;
    logic [ADDR_WIDTH-1:0]              aw_addr;
    logic [DATA_WIDTH+SW-1:0]           w_pay;
    logic [DATA_WIDTH-1:0]              w_data;
    logic [SW-1:0]                      w_strb;
    logic [IW-1:0]                      idx;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                pulse_q, pulse_d;
    logic                               bvalid_q, bvalid_d;
    axi_resp_e                          bresp_q, bresp_d;
    logic                               unused_ok;

    axi_lite_hold_buf #(.W(ADDR_WIDTH)) u_aw (
        .clk(clk), .rst_i(rst_i), .in_data(awaddr), .in_valid(awvalid), .in_ready(awready),
        .clr(commit), .full(aw_full), .data(aw_addr)
    );

    axi_lite_hold_buf #(.W(DATA_WIDTH + SW)) u_w (
        .clk(clk), .rst_i(rst_i), .in_data({wstrb, wdata}), .in_valid(wvalid), .in_ready(wready),
        .clr(commit), .full(w_full), .data(w_pay)
    );

    assign {w_strb, w_data} = w_pay;
    assign commit = aw_full & w_full & (~bvalid_q | bready);
    assign idx    = aw_addr[ADDR_WIDTH-1:2];
    assign err    = ERR_MAP[idx];

    // decode, byte-strobe merge, write pulse and B channel next state
    always_comb begin
        regs_d   = regs_q;
        pulse_d  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pulse_d[i] = commit & ~err & (idx == IW'(i));
            for (int b = 0; b < SW; b++)
                if (pulse_d[i] & w_strb[b]) regs_d[i][8*b +: 8] = w_data[8*b +: 8];
        end
        bvalid_d = commit | (bvalid_q & ~bready);
        bresp_d  = commit ? (err ? RESP_SLVERR : RESP_OKAY) : bresp_q;
    end

    // register bank and response state
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            regs_q   <= {NUM_REGS{RST_VAL}};
            pulse_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            regs_q   <= regs_d;
            pulse_q  <= pulse_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    assign regs_o     = regs_q;
    assign wr_pulse_o = pulse_q;
    assign bvalid     = bvalid_q;
    assign bresp      = bresp_q;
    assign unused_ok  = ^{awprot, aw_addr[1:0]};
endmodule

// File: tb/tb_axi_lite_wr_slave.sv
// tb_axi_lite_wr_slave: scoreboard bench for the AXI4-Lite write responder
module tb_axi_lite_wr_slave;
    localparam int NR = 8;
    localparam logic [NR-1:0] RO = 8'h80;
    localparam logic [31:0] RV = 32'h0000_00A5;

    logic clk = 0, rst_i = 0;
    logic [5:0] awaddr = 0;
    logic [2:0] awprot = 0;
    logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic [31:0] wdata = 0;
    logic [3:0] wstrb = 0;
    logic [1:0] bresp;
    logic [NR*32-1:0] regs_o;
    logic [NR-1:0] wr_pulse_o;

    axi_lite_wr_slave #(.NUM_REGS(NR), .RO_MASK(RO), .RST_VAL(RV)) dut (
        .clk(clk), .rst_i(rst_i), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   resp;
        logic [7:0]   pulse;
        logic [255:0] regs;
    } exp_t;

    exp_t q[$];
    logic [7:0][31:0] m = {NR{RV}};
    int n_chk = 0, n_fail = 0, nb = 0, nw = 0;
    logic rnd_br = 0;
    logic prev_bv = 0, prev_br = 0;
    logic [1:0] prev_resp = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        logic [3:0] ix;
        ix = a[5:2];
        e.pulse = 0;
        if (ix >= NR || RO[ix[2:0]]) e.resp = 2'b10;
        else begin
            e.resp = 2'b00;
            e.pulse[ix[2:0]] = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) m[ix[2:0]][8*b +: 8] = d[8*b +: 8];
        end
        e.regs = m;
        q.push_back(e);
        nw++;
    endtask

    task automatic aw_send(input logic [5:0] a);
        logic hs;
        int n = 0;
        awaddr = a;
        awprot = 3'($urandom_range(0, 7));
        awvalid = 1;
        do begin
            @(negedge clk);
            hs = awready;
            tick();
            n++;
        end while (!hs && n < 200);
        if (!hs) chk("aw_timeout", 0, 1);
        awvalid = 0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        logic hs;
        int n = 0;
        wdata = d;
        wstrb = s;
        wvalid = 1;
        do begin
            @(negedge clk);
            hs = wready;
            tick();
            n++;
        end while (!hs && n < 200);
        if (!hs) chk("w_timeout", 0, 1);
        wvalid = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int ad, input int wd);
        push_exp(a, d, s);
        fork
            begin repeat (ad) tick(); aw_send(a); end
            begin repeat (wd) tick(); w_send(d, s); end
        join
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin tick(); n++; end
        chk("drain", 256'(q.size()), 0);
    endtask

    // random B backpressure, changed just after the active edge
    initial forever begin
        tick();
        if (rnd_br) bready = ($urandom_range(0, 3) != 0);
    end

    // B monitor: pops one expectation per new response and checks hold rules
    initial forever begin
        @(negedge clk);
        if (!rst_i) begin
            prev_bv = 0;
            prev_br = 0;
        end else begin
            if (prev_bv && !prev_br) begin
                chk("b_hold", bvalid, 1);
                chk("bresp_hold", bresp, prev_resp);
            end
            if (bvalid && (!prev_bv || prev_br)) begin
                if (q.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("bresp", bresp, e.resp);
                    chk("pulse", wr_pulse_o, e.pulse);
                    chk("regs", regs_o, e.regs);
                    nb++;
                end
            end else chk("pulse_idle", wr_pulse_o, 0);
            prev_bv = bvalid;
            prev_br = bready;
            prev_resp = bresp;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_pulse", wr_pulse_o, 0);
        chk("rst_regs", regs_o, {NR{RV}});
        rst_i = 1;
        tick();
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);

        bready = 1;
        wr(6'h08, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("lat_pre_bvalid", bvalid, 0);
        tick();
        chk("lat_bvalid", bvalid, 1);
        chk("lat_bresp", bresp, 0);
        chk("lat_pulse", wr_pulse_o, 8'h04);
        chk("lat_reg2", regs_o[95:64], 32'hDEADBEEF);
        tick();

        wr(6'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
        repeat (2) tick();
        push_exp(6'h04, 32'h12345678, 4'h5);
        w_send(32'h12345678, 4'h5);
        repeat (3) begin
            tick();
            chk("wready_low", wready, 0);
        end
        aw_send(6'h04);
        tick();
        chk("wready_back", wready, 1);
        chk("reg1_merge", regs_o[63:32], 32'hFF34FF78);
        tick();

        wr(6'h3C, 32'h11111111, 4'hF, 0, 0);
        wr(6'h1C, 32'h22222222, 4'hF, 1, 0);
        repeat (2) tick();
        chk("ro_reg7", regs_o[255:224], RV);

        wr(6'h20, 32'h0BADF00D, 4'h0, 0, 2);
        repeat (2) tick();

        bready = 0;
        wr(6'h00, 32'hCAFE0001, 4'hF, 0, 0);
        wr(6'h1C, 32'h00005555, 4'hF, 0, 0);
        chk("stall_awready", awready, 0);
        chk("stall_wready", wready, 0);
        chk("stall_bvalid", bvalid, 1);
        repeat (5) tick();
        bready = 1;
        tick();
        chk("b2b_bvalid", bvalid, 1);
        chk("b2b_bresp", bresp, 2'b10);
        tick();
        chk("b2b_done", bvalid, 0);
        drain();

        aw_send(6'h10);
        #2;
        rst_i = 0;
        #1;
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_wready", wready, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_regs", regs_o, {NR{RV}});
        m = {NR{RV}};
        repeat (2) tick();
        rst_i = 1;
        repeat (10) tick();
        chk("no_b_after_rst", bvalid, 0);
        chk("post_rst_awready", awready, 1);

        rnd_br = 1;
        for (int i = 0; i < 100; i++)
            wr(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3));
        tick();
        rnd_br = 0;
        bready = 1;
        drain();
        repeat (3) tick();
        chk("b_count", 256'(nb), 256'(nw));
        chk("final_regs", regs_o, m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
